// File: rtl/uart_frame_rx_pkg.sv
// Shared types for the UART message receiver: character-FSM states and parity modes.
package uart_rx_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4,
        ST_BREAK  = 3'd5
    } char_state_e;

endpackage

// File: rtl/uart_frame_rx_if.sv
// Message handshake bus between the receiver (master) and the command parser (slave).
interface uart_frame_rx_if #(
    parameter int DATA_BITS = 8,
    parameter int MAX_CHARS = 18
);
    logic [MAX_CHARS*DATA_BITS-1:0]   frame_bus;
    logic [$clog2(MAX_CHARS+1)-1:0]   frame_len;
    logic                             frame_err;
    logic                             frame_valid;
    logic                             frame_ready;

    modport master (output frame_bus, frame_len, frame_err, frame_valid, input frame_ready);
    modport slave  (input frame_bus, frame_len, frame_err, frame_valid, output frame_ready);
endinterface

// File: rtl/uart_frame_rx_char.sv
// Synchroniser plus per-character UART decoder; emits one-cycle pulses per decoded character.
module uart_rx_char
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 baud_clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 rxs,
    output logic                 char_idle,
    output logic                 char_valid,
    output logic [DATA_BITS-1:0] char_data,
    output logic                 char_perr,
    output logic                 char_ferr,
    output logic                 stop_sample
);
    localparam int CNT_W = $clog2(OVERSAMPLE);
    localparam int BIT_W = $clog2(DATA_BITS + 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);
    localparam logic             ODD_BIT   = (PARITY == PAR_ODD);

    logic                 r_sync1, r_sync2, r_rxsPrev;
    char_state_e          r_state;
    logic [CNT_W-1:0]     r_osCnt;
    logic [BIT_W-1:0]     r_bitCnt;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr, r_ferr;
    logic                 r_charValid, r_charFerr, r_stopSample;
    logic                 w_fall, w_tick, w_stopBad;

    assign w_fall    = r_rxsPrev & ~r_sync2;
    assign w_tick    = (r_osCnt == FULL_LAST);
    assign w_stopBad = r_ferr | ~r_sync2;

    assign rxs         = r_sync2;
    assign char_idle   = (r_state == ST_IDLE);
    assign char_valid  = r_charValid;
    assign char_data   = r_shift;
    assign char_perr   = r_perr;
    assign char_ferr   = r_charFerr;
    assign stop_sample = r_stopSample;

    // Sample points sit mid-bit: half a bit after the start edge, then one full bit apart.
    always_ff @(posedge baud_clk) begin
        if (rst) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_rxsPrev    <= 1'b1;
            r_state      <= ST_IDLE;
            r_osCnt      <= '0;
            r_bitCnt     <= '0;
            r_shift      <= '0;
            r_perr       <= 1'b0;
            r_ferr       <= 1'b0;
            r_charValid  <= 1'b0;
            r_charFerr   <= 1'b0;
            r_stopSample <= 1'b0;
        end else begin
            r_sync1      <= rx;
            r_sync2      <= r_sync1;
            r_rxsPrev    <= r_sync2;
            r_charValid  <= 1'b0;
            r_charFerr   <= 1'b0;
            r_stopSample <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (w_fall) begin
                        r_state  <= ST_START;
                        r_osCnt  <= '0;
                        r_bitCnt <= '0;
                        r_perr   <= 1'b0;
                        r_ferr   <= 1'b0;
                    end
                end
                ST_START: begin
                    if (r_osCnt == HALF_LAST) begin
                        r_osCnt <= '0;
                        r_state <= r_sync2 ? ST_IDLE : ST_DATA;
                    end else begin
                        r_osCnt <= r_osCnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_tick) begin
                        r_osCnt <= '0;
                        r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
                        if (r_bitCnt == DATA_LAST) begin
                            r_bitCnt <= '0;
                            r_state  <= (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                        end else begin
                            r_bitCnt <= r_bitCnt + 1'b1;
                        end
                    end else begin
                        r_osCnt <= r_osCnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (w_tick) begin
                        r_osCnt <= '0;
                        r_perr  <= (^r_shift) ^ r_sync2 ^ ODD_BIT;
                        r_state <= ST_STOP;
                    end else begin
                        r_osCnt <= r_osCnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (w_tick) begin
                        r_osCnt      <= '0;
                        r_stopSample <= 1'b1;
                        if (r_bitCnt == STOP_LAST) begin
                            r_bitCnt <= '0;
                            if (w_stopBad) begin
                                r_charFerr <= 1'b1;
                                r_state    <= ST_BREAK;
                            end else begin
                                r_charValid <= 1'b1;
                                r_state     <= ST_IDLE;
                            end
                        end else begin
                            r_ferr   <= w_stopBad;
                            r_bitCnt <= r_bitCnt + 1'b1;
                        end
                    end else begin
                        r_osCnt <= r_osCnt + 1'b1;
                    end
                end
                ST_BREAK: begin
                    if (r_sync2) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_frame_rx.sv
// Message receiver top: packs decoded characters, closes messages on an idle gap, holds them for the parser.
module uart_frame_rx
    import uart_rx_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16,
    parameter int MAX_CHARS  = 18,
    parameter int IDLE_BITS  = 7
) (
    input  logic            baud_clk,
    input  logic            rst,
    input  logic            rx,
    uart_frame_rx_if.master frm,
    output logic            overflow
);
    localparam int BUS_W     = MAX_CHARS * DATA_BITS;
    localparam int LEN_W     = $clog2(MAX_CHARS + 1);
    localparam int IDLE_TERM = IDLE_BITS * OVERSAMPLE;
    localparam int IDLE_W    = $clog2(IDLE_TERM + 2);
    localparam logic [IDLE_W-1:0] IDLE_DONE = IDLE_W'(IDLE_TERM);
    localparam logic [IDLE_W-1:0] IDLE_PAST = IDLE_W'(IDLE_TERM + 1);
    localparam logic [LEN_W-1:0]  LEN_FULL  = LEN_W'(MAX_CHARS);

    logic                 w_rxs, w_idle, w_charValid, w_perr, w_ferr, w_stopSample;
    logic [DATA_BITS-1:0] w_charData;
    logic                 w_idleDone, w_hasChars, w_publish, w_msgDrop, w_charDrop;

    logic [BUS_W-1:0]  r_asmBuf, r_busOut;
    logic [LEN_W-1:0]  r_len, r_lenOut;
    logic              r_asmErr, r_errOut, r_validOut, r_overflow;
    logic [IDLE_W-1:0] r_idleCnt;

    uart_rx_char #(
        .DATA_BITS (DATA_BITS),
        .PARITY    (PARITY),
        .STOP_BITS (STOP_BITS),
        .OVERSAMPLE(OVERSAMPLE)
    ) u_char (
        .baud_clk   (baud_clk),
        .rst        (rst),
        .rx         (rx),
        .rxs        (w_rxs),
        .char_idle  (w_idle),
        .char_valid (w_charValid),
        .char_data  (w_charData),
        .char_perr  (w_perr),
        .char_ferr  (w_ferr),
        .stop_sample(w_stopSample)
    );

    assign w_idleDone = (r_idleCnt == IDLE_DONE);
    assign w_hasChars = (r_len != '0);
    assign w_publish  = w_idleDone && w_hasChars && (!r_validOut || frm.frame_ready);
    assign w_msgDrop  = w_idleDone && w_hasChars && r_validOut && !frm.frame_ready;
    assign w_charDrop = w_charValid && (r_len == LEN_FULL);

    assign frm.frame_bus   = r_busOut;
    assign frm.frame_len   = r_lenOut;
    assign frm.frame_err   = r_errOut;
    assign frm.frame_valid = r_validOut;
    assign overflow        = r_overflow;

    // Unfilled slots stay all ones so the published bus needs no masking.
    always_ff @(posedge baud_clk) begin
        if (rst) begin
            r_asmBuf <= '1;
            r_len    <= '0;
            r_asmErr <= 1'b0;
        end else if (w_idleDone) begin
            r_asmBuf <= '1;
            r_len    <= '0;
            r_asmErr <= 1'b0;
        end else begin
            if (w_charValid && !w_charDrop) begin
                r_asmBuf[int'(r_len) * DATA_BITS +: DATA_BITS] <= w_charData;
                r_len <= r_len + 1'b1;
            end
            if ((w_charValid && w_perr) || w_ferr) r_asmErr <= 1'b1;
        end
    end

    // Parks one past terminal so each idle gap closes a message exactly once.
    always_ff @(posedge baud_clk) begin
        if (rst) begin
            r_idleCnt <= '0;
        end else if (w_stopSample) begin
            r_idleCnt <= '0;
        end else if (w_idleDone) begin
            r_idleCnt <= IDLE_PAST;
        end else if (w_idle && w_rxs && (r_idleCnt < IDLE_DONE)) begin
            r_idleCnt <= r_idleCnt + 1'b1;
        end
    end

    always_ff @(posedge baud_clk) begin
        if (rst) begin
            r_busOut   <= '1;
            r_lenOut   <= '0;
            r_errOut   <= 1'b0;
            r_validOut <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            r_overflow <= w_charDrop | w_msgDrop;
            if (w_publish) begin
                r_busOut   <= r_asmBuf;
                r_lenOut   <= r_len;
                r_errOut   <= r_asmErr;
                r_validOut <= 1'b1;
            end else if (r_validOut && frm.frame_ready) begin
                r_validOut <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_rx.sv
// Directed bench: two receivers (plain 18-char, even-parity 2-char) checked against a message-level model.
module tb_uart_frame_rx;

    typedef struct {
        logic [143:0] bus;
        int           len;
        bit           err;
    } msg_t;

    logic clk = 1'b0;
    logic rst;
    logic rxA, rxB;
    logic ovfA, ovfB;

    int   nChecks = 0;
    int   nErrors = 0;
    msg_t expA[$];
    msg_t expB[$];
    int   rdA = 0, rdB = 0;
    int   ovCntA = 0, ovCntB = 0;
    int   ovExpA = 0, ovExpB = 0;
    logic [7:0] pend[$];
    bit   pendErr = 1'b0;
    bit   seen;

    always #5 clk = ~clk;

    uart_frame_rx_if #(.DATA_BITS(8), .MAX_CHARS(18)) ifA ();
    uart_frame_rx_if #(.DATA_BITS(8), .MAX_CHARS(2))  ifB ();

    uart_frame_rx #(
        .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .OVERSAMPLE(16), .MAX_CHARS(18), .IDLE_BITS(7)
    ) dutA (
        .baud_clk(clk), .rst(rst), .rx(rxA), .frm(ifA), .overflow(ovfA)
    );

    uart_frame_rx #(
        .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .OVERSAMPLE(16), .MAX_CHARS(2), .IDLE_BITS(7)
    ) dutB (
        .baud_clk(clk), .rst(rst), .rx(rxB), .frm(ifB), .overflow(ovfB)
    );

    task automatic checkOutput(input string name, input logic [143:0] act, input logic [143:0] req);
        nChecks++;
        if (act !== req) begin
            nErrors++;
            $display("[TB] FAIL %s: got %0h, want %0h", name, act, req);
        end
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic applyStimulus(input int sel, input logic v, input int cycles);
        if (sel == 0) rxA = v;
        else          rxB = v;
        waitCycles(cycles);
    endtask

    task automatic sendChar(input int sel, input logic [7:0] data, input bit usePar, input bit parBit);
        applyStimulus(sel, 1'b0, 16);
        for (int i = 0; i < 8; i++) applyStimulus(sel, data[i], 16);
        if (usePar) applyStimulus(sel, parBit, 16);
        applyStimulus(sel, 1'b1, 16);
        pend.push_back(data);
        if (usePar && (parBit != ^data)) pendErr = 1'b1;
    endtask

    // Turns the characters sent since the last gap into the message the consumer must see.
    task automatic closeMsg(input int sel, input bit dropped);
        msg_t m;
        int   maxc;
        maxc  = (sel == 0) ? 18 : 2;
        m.bus = '1;
        m.len = 0;
        m.err = pendErr;
        for (int i = 0; i < pend.size(); i++) begin
            if (i < maxc) begin
                m.bus[i*8 +: 8] = pend[i];
                m.len++;
            end else if (sel == 0) ovExpA++;
            else ovExpB++;
        end
        if (dropped) begin
            if (sel == 0) ovExpA++;
            else ovExpB++;
        end else if (sel == 0) expA.push_back(m);
        else expB.push_back(m);
        pend.delete();
        pendErr = 1'b0;
    endtask

    task automatic waitValid(input int sel, input int budget, output bit found);
        found = 1'b0;
        for (int k = 0; k < budget && !found; k++) begin
            @(negedge clk);
            if ((sel == 0) ? ifA.frame_valid : ifB.frame_valid) found = 1'b1;
        end
        if (!found) checkOutput((sel == 0) ? "A_valid_timeout" : "B_valid_timeout", 144'(found), 144'(1));
    endtask

    // Every cycle a message is offered, it must match the oldest undelivered model message.
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            if (ifA.frame_valid) begin
                if (rdA >= expA.size()) checkOutput("A_unexpected_valid", 144'(ifA.frame_valid), 144'(0));
                else begin
                    checkOutput("A_bus", ifA.frame_bus, expA[rdA].bus);
                    checkOutput("A_len", 144'(ifA.frame_len), 144'(expA[rdA].len));
                    checkOutput("A_err", 144'(ifA.frame_err), 144'(expA[rdA].err));
                    if (ifA.frame_ready) rdA = rdA + 1;
                end
            end
            if (ifB.frame_valid) begin
                if (rdB >= expB.size()) checkOutput("B_unexpected_valid", 144'(ifB.frame_valid), 144'(0));
                else begin
                    checkOutput("B_bus", 144'(ifB.frame_bus), 144'(expB[rdB].bus[15:0]));
                    checkOutput("B_len", 144'(ifB.frame_len), 144'(expB[rdB].len));
                    checkOutput("B_err", 144'(ifB.frame_err), 144'(expB[rdB].err));
                    if (ifB.frame_ready) rdB = rdB + 1;
                end
            end
            if (ovfA) ovCntA++;
            if (ovfB) ovCntB++;
        end
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        rst = 1'b1;
        rxA = 1'b1;
        rxB = 1'b1;
        ifA.frame_ready = 1'b0;
        ifB.frame_ready = 1'b1;
        waitCycles(4);
        rst = 1'b0;
        waitCycles(2);

        checkOutput("rst_A_valid", 144'(ifA.frame_valid), 144'(0));
        checkOutput("rst_A_len",   144'(ifA.frame_len),   144'(0));
        checkOutput("rst_A_bus",   ifA.frame_bus,         {144{1'b1}});
        checkOutput("rst_A_err",   144'(ifA.frame_err),   144'(0));
        checkOutput("rst_A_ovf",   144'(ovfA),            144'(0));
        checkOutput("rst_B_bus",   144'(ifB.frame_bus),   144'(16'hFFFF));

        // Two back-to-back characters, held until the consumer is ready.
        sendChar(0, 8'h41, 1'b0, 1'b0);
        sendChar(0, 8'h42, 1'b0, 1'b0);
        closeMsg(0, 1'b0);
        waitValid(0, 400, seen);
        checkOutput("s1_len",  144'(ifA.frame_len),          144'(2));
        checkOutput("s1_lo16", 144'(ifA.frame_bus[15:0]),    144'(16'h4241));
        checkOutput("s1_hi",   144'(ifA.frame_bus[143:16]),  144'({128{1'b1}}));
        checkOutput("s1_err",  144'(ifA.frame_err),          144'(0));
        waitCycles(3);
        ifA.frame_ready = 1'b1;
        waitCycles(1);
        checkOutput("s1_valid_fall", 144'(ifA.frame_valid), 144'(0));

        // One-cycle glitch is a false start.
        applyStimulus(0, 1'b0, 1);
        applyStimulus(0, 1'b1, 300);
        checkOutput("glitch_no_valid", 144'(ifA.frame_valid), 144'(0));

        // Even parity receiver: 0x03 with parity bit 1 is a parity error.
        sendChar(1, 8'h03, 1'b1, 1'b1);
        closeMsg(1, 1'b0);
        waitValid(1, 400, seen);
        checkOutput("par_err",  144'(ifB.frame_err),      144'(1));
        checkOutput("par_byte", 144'(ifB.frame_bus[7:0]), 144'(8'h03));
        checkOutput("par_len",  144'(ifB.frame_len),      144'(1));
        waitCycles(1);

        // Third character into a two-slot receiver is dropped.
        sendChar(1, 8'h11, 1'b1, 1'b0);
        sendChar(1, 8'h22, 1'b1, 1'b0);
        sendChar(1, 8'h33, 1'b1, 1'b0);
        closeMsg(1, 1'b0);
        waitValid(1, 400, seen);
        checkOutput("ovf_len", 144'(ifB.frame_len), 144'(2));
        checkOutput("ovf_bus", 144'(ifB.frame_bus), 144'(16'h2211));
        waitCycles(2);
        checkOutput("ovf_B_once", 144'(ovCntB), 144'(1));

        // Second message arrives while the first is still unaccepted.
        ifA.frame_ready = 1'b0;
        sendChar(0, 8'h10, 1'b0, 1'b0);
        closeMsg(0, 1'b0);
        waitValid(0, 400, seen);
        waitCycles(1);
        sendChar(0, 8'h20, 1'b0, 1'b0);
        closeMsg(0, 1'b1);
        applyStimulus(0, 1'b1, 200);
        checkOutput("drop_ovf_once",  144'(ovCntA),               144'(1));
        checkOutput("drop_keep_byte", 144'(ifA.frame_bus[7:0]),   144'(8'h10));
        checkOutput("drop_keep_len",  144'(ifA.frame_len),        144'(1));
        ifA.frame_ready = 1'b1;
        waitCycles(1);
        checkOutput("drop_valid_fall", 144'(ifA.frame_valid), 144'(0));

        // Reset in the middle of data bit 4 of the second character.
        sendChar(0, 8'h61, 1'b0, 1'b0);
        applyStimulus(0, 1'b0, 16);
        for (int i = 0; i < 4; i++) applyStimulus(0, (8'h62 >> i) & 8'h01, 16);
        applyStimulus(0, 1'b0, 8);
        rst = 1'b1;
        rxA = 1'b1;
        pend.delete();
        pendErr = 1'b0;
        waitCycles(3);
        checkOutput("mid_rst_valid", 144'(ifA.frame_valid), 144'(0));
        checkOutput("mid_rst_len",   144'(ifA.frame_len),   144'(0));
        checkOutput("mid_rst_bus",   ifA.frame_bus,         {144{1'b1}});
        rst = 1'b0;
        waitCycles(300);
        checkOutput("mid_rst_no_publish", 144'(ifA.frame_valid), 144'(0));
        sendChar(0, 8'h55, 1'b0, 1'b0);
        closeMsg(0, 1'b0);
        waitValid(0, 400, seen);
        checkOutput("fresh_len",  144'(ifA.frame_len),       144'(1));
        checkOutput("fresh_byte", 144'(ifA.frame_bus[7:0]),  144'(8'h55));
        checkOutput("fresh_pad",  144'(ifA.frame_bus[15:8]), 144'(8'hFF));
        waitCycles(2);

        checkOutput("A_all_delivered", 144'(rdA),    144'(expA.size()));
        checkOutput("B_all_delivered", 144'(rdB),    144'(expB.size()));
        checkOutput("A_ovf_total",     144'(ovCntA), 144'(ovExpA));
        checkOutput("B_ovf_total",     144'(ovCntB), 144'(ovExpB));

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
